// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one down-count timer between NREQ requesters.
// Optional build macro TIMER_ARB_ABORT_EN: winner dropping req during COUNT cancels the wait.
module timer_arbiter #(
    parameter int NREQ = 4,
    parameter int CW   = 6,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*CW-1:0]   req_delay,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 busy,
    output logic [IDW-1:0]       cur_id
);

    // state | meaning
    // IDLE  | timer free, arbitrating among pending requests
    // COUNT | timer owned by cur_id, counting its captured delay to zero
    // DONE  | one-cycle done pulse to cur_id, pointer advanced
    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [IDW-1:0]  rr_ptr, rr_d, id_d;
    logic [NREQ-1:0] gnt_d, done_d;
    logic            busy_d;

    logic [NREQ-1:0] req_rot;
    logic            found;
    logic [IDW-1:0]  win;
    logic [IDW:0]    win_sum;
    logic [CW-1:0]   win_delay;
    logic [NREQ-1:0] win_onehot, cur_onehot;
    logic [IDW-1:0]  next_id;

    // Rotate requests so bit 0 is rr_ptr; the first set bit is the winner's offset.
    always_comb begin
        req_rot = NREQ'({req, req} >> rr_ptr);
        found   = 1'b0;
        win_sum = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_rot[i]) begin
                found   = 1'b1;
                win_sum = {1'b0, rr_ptr} + (IDW+1)'(i);
            end
        end
        if (win_sum >= (IDW+1)'(NREQ))
            win_sum = win_sum - (IDW+1)'(NREQ);
        win = IDW'(win_sum);
    end

    always_comb begin
        win_delay  = '0;
        win_onehot = '0;
        cur_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == win) begin
                win_delay     = req_delay[i*CW +: CW];
                win_onehot[i] = 1'b1;
            end
            if (IDW'(i) == cur_id)
                cur_onehot[i] = 1'b1;
        end
        next_id = (cur_id == IDW'(NREQ-1)) ? '0 : cur_id + IDW'(1);
    end

`ifdef TIMER_ARB_ABORT_EN
    logic req_cur;
    assign req_cur = |(req & cur_onehot);
`endif

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        rr_d    = rr_ptr;
        id_d    = cur_id;
        gnt_d   = gnt;
        done_d  = '0;
        busy_d  = busy;
        case (state)
            IDLE: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                if (found) begin
                    state_d = COUNT;
                    cnt_d   = win_delay;
                    id_d    = win;
                    gnt_d   = win_onehot;
                    busy_d  = 1'b1;
                end
            end
            COUNT: begin
`ifdef TIMER_ARB_ABORT_EN
                if (!req_cur) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    rr_d    = next_id;
                end else
`endif
                if (cnt == '0) begin
                    state_d = DONE;
                    gnt_d   = '0;
                    done_d  = cur_onehot;
                    rr_d    = next_id;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            rr_ptr <= '0;
            cur_id <= '0;
            gnt    <= '0;
            done   <= '0;
            busy   <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            rr_ptr <= rr_d;
            cur_id <= id_d;
            gnt    <= gnt_d;
            done   <= done_d;
            busy   <= busy_d;
        end
    end

endmodule

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
- Shares one 6-bit down-count timer between NREQ requesters, each of which needs a programmable delay.
- Round-robin arbiter grants the timer to one requester at a time.
- Loads that requester's delay, counts to zero, then pulses done back to the winner.
- Sits between control FSMs that need wait states and the single timer resource, so each FSM does not need its own counter.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CW, 6, counter/delay width in bits.
- IDW, 2, width of cur_id; must equal ceil(log2(NREQ)).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester timer request; level, held until done.
- req_delay  input  NREQ*CW  packed delays; requester i uses bits [i*CW +: CW].
- gnt  output  NREQ  one-hot grant; high while the winner owns the timer.
- done  output  NREQ  one-cycle pulse to the winner when its delay expires.
- busy  output  1  high in any state except IDLE.
- cur_id  output  IDW  index of the current/last winner.

Behaviour:
- Reset (async, immediate on rst high, any state):
  - state=IDLE, cnt=0, rr_ptr=0.
  - gnt=0, done=0, busy=0, cur_id=0.
  - No done pulse is emitted for an operation interrupted by reset.
- States: IDLE, COUNT, DONE.
- IDLE:
  - If any req is high, pick the first set bit scanning from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NREQ-1, 0, ...).
  - Next edge: state=COUNT, cnt=req_delay[winner], gnt[winner]=1, cur_id=winner, busy=1.
  - With no req high, stay in IDLE; outputs hold at 0 except cur_id, which keeps its last value.
- COUNT:
  - cnt>0: cnt decrements by 1 each cycle.
  - cnt==0: next edge goes to DONE.
  - The delay is captured at grant; later changes to req_delay have no effect.
- DONE (exactly one cycle):
  - done[cur_id]=1, gnt=0, busy=1.
  - rr_ptr=(cur_id+1) mod NREQ.
  - Next edge goes to IDLE.
- Timing, for a request arbitrated in IDLE at cycle t with delay D:
  - gnt is high for cycles t+1 .. t+D+1, i.e. D+1 cycles.
  - done pulses at cycle t+D+2.
  - Earliest next grant is at t+D+4, since IDLE consumes one cycle.
- D=0: gnt high one cycle, done at t+2.
- D=2^CW-1 (63 at default CW): gnt high 64 cycles, with no wrap (cnt never underflows).
- Simultaneous requests: only one winner per arbitration. Losers keep waiting; their req must stay high.
- Fairness: a requester that re-raises req immediately after its done loses to any other pending requester.
- The winner may drop req on the done cycle or later; it must not re-raise before seeing done.
- Invalid inputs: req bits for a non-winner changing during COUNT/DONE have no effect.
- Outputs are registered; done and gnt are glitch-free.

Optional Feature:
- Macro: TIMER_ARB_ABORT_EN.
- Defined: if req[cur_id] goes low while in COUNT, the next edge goes to IDLE.
  - gnt=0, busy=0, no done pulse, cnt=0.
  - rr_ptr=(cur_id+1) mod NREQ.
  - Lets a requester cancel a pending wait.
- Not defined: req of the winner is ignored after grant. The count runs to completion and done still pulses.

Test Plan:
- Reset, then req=4'b0001 with delay 3 → gnt=0001 for 4 cycles, done[0] pulses exactly 5 cycles after the arbitration cycle, cur_id=0, busy drops the cycle after done.
- req=4'b1010 simultaneously with delays 1 and 2, rr_ptr=0 → requester 1 is granted first and done[1] follows. Requester 3 is then granted with gnt=1000 for 3 cycles, then done[3]; rr_ptr ends at 0.
- Delay 0 on requester 2 → gnt=0100 for exactly one cycle, done[2] two cycles after arbitration. Max delay 63 → gnt high 64 cycles with no early done.
- req_delay[0] changed from 5 to 1 one cycle after grant → done still occurs 5+2 cycles after arbitration.
- Winner drops req mid-count:
  - with TIMER_ARB_ABORT_EN → busy low next cycle, no done, next requester granted.
  - without it → done still pulses at the original time.
- Assert rst asynchronously mid-COUNT (between clock edges) → gnt, done and busy go to 0 immediately. After release with req held high, requester 0 is regranted from a fresh full delay.
